// File: rtl/bcd_display_scanner_if.sv
// Bus bundle between a BCD digit source and the multiplexed 7-segment scanner.
// The master drives the digits and strobes; the slave returns display drive and status.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;
  logic                    err;

  modport master (
    output bcd_in, dp_in, load, blank_lz,
    input  seg, dp, an, digit_idx, frame_done, err
  );

  modport slave (
    input  bcd_in, dp_in, load, blank_lz,
    output seg, dp, an, digit_idx, frame_done, err
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Shadows NUM_DIGITS BCD digits on load and time-multiplexes them onto one 7-segment
// driver with leading-zero blanking, per-digit decimal point and a sticky invalid-code flag.
module bcd_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int COMMON_ANODE = 1
) (
  input  logic                   clk,
  input  logic                   clear,
  bcd_display_scanner_if.slave   bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             INV      = (COMMON_ANODE != 0);
  localparam logic [6:0]       SEG_OFF  = INV ? 7'h7F : 7'h00;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic has_invalid(input logic [4*NUM_DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic [CNT_W-1:0]        cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    err_r;

  logic [6:0]              seg_p1;
  logic                    dp_p1;
  logic [NUM_DIGITS-1:0]   an_p1;
  logic [IDX_W-1:0]        idx_p1;
  logic                    frame_done_p1;

  logic                    cnt_last;
  logic                    idx_last;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [6:0]              seg_next;

  assign cnt_last = (cnt_p0 == CNT_LAST);
  assign idx_last = (idx_p0 == IDX_LAST);

  // Blank mask: digit i>0 is blanked while every digit from the top down to i is zero.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow_digits[4*i +: 4] == 4'd0);
      if (i > 0) blank_mask[i] = zero_run & bus.blank_lz;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        cur_digit    = shadow_digits[4*i +: 4];
        cur_dp       = shadow_dp[i];
        cur_blank    = blank_mask[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_next = seg_decode(cur_digit);
    if (INV) seg_next = ~seg_next;
    if (cur_blank) seg_next = SEG_OFF;
  end

  // Stage p0: prescaler, scan index and shadow capture.
  always_ff @(posedge clk) begin
    if (!clear) begin
      cnt_p0        <= '0;
      idx_p0        <= '0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      err_r         <= 1'b0;
    end else begin
      if (cnt_last) begin
        cnt_p0 <= '0;
        idx_p0 <= idx_last ? '0 : idx_p0 + 1'b1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
      if (bus.load) begin
        shadow_digits <= bus.bcd_in;
        shadow_dp     <= bus.dp_in;
        if (has_invalid(bus.bcd_in)) err_r <= 1'b1;
      end
    end
  end

  // Stage p1: registered display drive, one cycle behind the scan index.
  always_ff @(posedge clk) begin
    if (!clear) begin
      seg_p1        <= SEG_OFF;
      dp_p1         <= INV;
      an_p1         <= INV ? '1 : '0;
      idx_p1        <= '0;
      frame_done_p1 <= 1'b0;
    end else begin
      seg_p1        <= seg_next;
      dp_p1         <= cur_dp ^ INV;
      an_p1         <= INV ? ~an_onehot : an_onehot;
      idx_p1        <= idx_p0;
      frame_done_p1 <= cnt_last & idx_last;
    end
  end

  assign bus.seg        = seg_p1;
  assign bus.dp         = dp_p1;
  assign bus.an         = an_p1;
  assign bus.digit_idx  = idx_p1;
  assign bus.frame_done = frame_done_p1;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench: a PRESCALE=4 scanner for slot/blanking/error behaviour and a PRESCALE=1
// scanner for per-cycle scanning, both common-anode with four digits.
module tb_bcd_display_scanner;

  logic clk;
  logic clear;
  int   tests;
  int   failed;

  bcd_display_scanner_if #(.NUM_DIGITS(4)) ifa ();
  bcd_display_scanner_if #(.NUM_DIGITS(4)) ifb ();

  bcd_display_scanner #(.NUM_DIGITS(4), .PRESCALE(4), .COMMON_ANODE(1)) dut_a (
    .clk   (clk),
    .clear (clear),
    .bus   (ifa)
  );

  bcd_display_scanner #(.NUM_DIGITS(4), .PRESCALE(1), .COMMON_ANODE(1)) dut_b (
    .clk   (clk),
    .clear (clear),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [15:0] v, input logic [3:0] d);
    ifa.bcd_in = v;
    ifa.dp_in  = d;
    ifa.load   = 1'b1;
    step();
    ifa.load   = 1'b0;
  endtask

  task automatic wait_fd_a(input string tag);
    int n;
    n = 0;
    while (ifa.frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_sync"}, {31'd0, ifa.frame_done}, 32'd1);
  endtask

  task automatic wait_fd_b(input string tag);
    int n;
    n = 0;
    while (ifb.frame_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_sync"}, {31'd0, ifb.frame_done}, 32'd1);
  endtask

  // segs = {digit3, digit2, digit1, digit0}; dpm marks digits whose decimal point is lit.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dpm);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    logic       ef;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        ea = ~(4'b0001 << d);
        es = segs[d*7 +: 7];
        ed = ~dpm[d];
        ef = (d == 3) && (c == 3);
        chk({tag, "_an"},  {28'd0, ifa.an}, {28'd0, ea});
        chk({tag, "_seg"}, {25'd0, ifa.seg}, {25'd0, es});
        chk({tag, "_idx"}, {30'd0, ifa.digit_idx}, d);
        chk({tag, "_dp"},  {31'd0, ifa.dp}, {31'd0, ed});
        chk({tag, "_fd"},  {31'd0, ifa.frame_done}, {31'd0, ef});
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_seg"}, {25'd0, ifa.seg}, 32'h7F);
    chk({tag, "_dp"},  {31'd0, ifa.dp}, 32'd1);
    chk({tag, "_an"},  {28'd0, ifa.an}, 32'hF);
    chk({tag, "_idx"}, {30'd0, ifa.digit_idx}, 32'd0);
    chk({tag, "_err"}, {31'd0, ifa.err}, 32'd0);
    chk({tag, "_fd"},  {31'd0, ifa.frame_done}, 32'd0);
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    clear        = 1'b0;
    ifa.bcd_in   = 16'h9999;
    ifa.dp_in    = 4'hF;
    ifa.load     = 1'b1;
    ifa.blank_lz = 1'b0;
    ifb.bcd_in   = 16'h9999;
    ifb.dp_in    = 4'hF;
    ifb.load     = 1'b1;
    ifb.blank_lz = 1'b0;

    // Reset held two cycles with load asserted: load must be ignored.
    step();
    step();
    check_reset("rst");
    chk("rst_b_an", {28'd0, ifb.an}, 32'hF);
    clear      = 1'b1;
    ifa.load   = 1'b0;
    ifb.load   = 1'b0;
    ifa.bcd_in = 16'h0000;
    ifa.dp_in  = 4'h0;
    check_frame("post_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);

    // Plain scan of 1234 with a decimal point on digit 2.
    load_a(16'h1234, 4'b0100);
    chk("err_1234", {31'd0, ifa.err}, 32'd0);
    wait_fd_a("s1234");
    check_frame("f1234a", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100);
    check_frame("f1234b", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100);

    // Leading-zero blanking; dp still shown on a blanked digit.
    ifa.blank_lz = 1'b1;
    load_a(16'h0007, 4'b1000);
    wait_fd_a("s0007");
    check_frame("lz0007", {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1000);
    load_a(16'h0000, 4'b0000);
    wait_fd_a("s0000");
    check_frame("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000);
    ifa.blank_lz = 1'b0;
    wait_fd_a("snolz");
    check_frame("nolz0000", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);

    // Invalid digit: dash, counts as non-zero for blanking, sticky err.
    ifa.blank_lz = 1'b1;
    load_a(16'h0A05, 4'b0000);
    chk("err_0a05", {31'd0, ifa.err}, 32'd1);
    wait_fd_a("s0a05");
    check_frame("lz0a05", {7'h7F, 7'h3F, 7'h40, 7'h12}, 4'b0000);
    ifa.blank_lz = 1'b0;
    wait_fd_a("s0a05n");
    check_frame("nolz0a05", {7'h40, 7'h3F, 7'h40, 7'h12}, 4'b0000);
    load_a(16'h1234, 4'b0000);
    chk("err_sticky", {31'd0, ifa.err}, 32'd1);
    wait_fd_a("s1234e");
    check_frame("f1234e", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);
    chk("err_sticky2", {31'd0, ifa.err}, 32'd1);

    // Clear mid-slot (prescaler=2) colliding with a load of 9999.
    step();
    step();
    clear      = 1'b0;
    ifa.bcd_in = 16'h9999;
    ifa.dp_in  = 4'hF;
    ifa.load   = 1'b1;
    step();
    check_reset("midclr");
    clear    = 1'b1;
    ifa.load = 1'b0;
    check_frame("after_clr", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);

    // PRESCALE=1: index advances every cycle, frame_done every 4th cycle.
    ifb.bcd_in = 16'h1234;
    ifb.dp_in  = 4'h0;
    ifb.load   = 1'b1;
    step();
    ifb.load   = 1'b0;
    wait_fd_b("sb");
    for (int c = 0; c < 8; c++) begin
      logic [6:0] es;
      logic       ef;
      step();
      case (c % 4)
        0:       es = 7'h19;
        1:       es = 7'h30;
        2:       es = 7'h24;
        default: es = 7'h79;
      endcase
      ef = ((c % 4) == 3);
      chk("b_idx", {30'd0, ifb.digit_idx}, c % 4);
      chk("b_seg", {25'd0, ifb.seg}, {25'd0, es});
      chk("b_fd",  {31'd0, ifb.frame_done}, {31'd0, ef});
    end
    ifb.bcd_in = 16'h5678;
    ifb.load   = 1'b1;
    step();
    ifb.load   = 1'b0;
    chk("b_old_seg", {25'd0, ifb.seg}, 32'h19);
    chk("b_old_idx", {30'd0, ifb.digit_idx}, 32'd0);
    step();
    chk("b_new1_seg", {25'd0, ifb.seg}, 32'h78);
    chk("b_new1_idx", {30'd0, ifb.digit_idx}, 32'd1);
    step();
    chk("b_new2_seg", {25'd0, ifb.seg}, 32'h02);
    step();
    chk("b_new3_seg", {25'd0, ifb.seg}, 32'h12);
    chk("b_new3_fd",  {31'd0, ifb.frame_done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
